sprite_pixel_fetch: RTL and testbench

SPRITE_PIXEL_FETCH -- requirements
Module: sprite_pixel_fetch

---
 rtl/sprite_pixel_fetch.sv | 93 +++++++++
 tb/tb_sprite_pixel_fetch.sv | 183 ++++++++++++++++++
 2 files changed

// File: rtl/sprite_pixel_fetch.sv
// sprite_pixel_fetch: three-stage sprite hit test, pixel/palette fetch and colour select for 8 sprite slots
module sprite_pixel_fetch #(
  parameter int MAIN0_X = 64,
  parameter int MAIN0_Y = 48,
  parameter int MAIN1_X = 384,
  parameter int MAIN1_Y = 48,
  parameter int BAR_X = 16,
  parameter int BAR_Y = 400,
  parameter int BAR_STEP = 104,
  parameter logic [23:0] BG_RGB = 24'h000000,
  parameter logic [23:0] HL_RGB = 24'hFFFF00
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [9:0]  hcount,
  input  logic [9:0]  vcount,
  input  logic        active,
  input  logic [7:0]  slot_en,
  input  logic [2:0]  cursor,
  output logic [14:0] addr_out,
  input  logic [3:0]  q,
  output logic [7:0]  addr_outh,
  input  logic [23:0] qh,
  output logic [23:0] rgb,
  output logic        rgb_valid
);
  function automatic logic [10:0] sx(input int k);
    return 11'(k == 0 ? MAIN0_X : k == 1 ? MAIN1_X : BAR_X + (k - 2) * BAR_STEP);
  endfunction
  function automatic logic [10:0] sy(input int k);
    return 11'(k == 0 ? MAIN0_Y : k == 1 ? MAIN1_Y : BAR_Y);
  endfunction
  logic [7:0] en_sh;
  logic [2:0] cur_sh, slot, slot1;
  logic [10:0] h11, v11;
  logic [5:0] dh, dv;
  logic hit, on_edge, hit1, brd1, act1, hit2, brd2, act2;
  logic [3:0] q_r;
  assign h11 = {1'b0, hcount};
  assign v11 = {1'b0, vcount};
  assign on_edge = dh == 6'd0 || dh == 6'd63 || dv == 6'd0 || dv == 6'd63;
  // descending scan so the lowest-numbered hit is the one left standing
  always_comb begin
    hit = 1'b0;
    slot = '0;
    dh = '0;
    dv = '0;
    for (int k = 7; k >= 0; k--)
      if (en_sh[k] && h11 >= sx(k) && h11 <= sx(k) + 11'd63 && v11 >= sy(k) && v11 <= sy(k) + 11'd63) begin
        hit = 1'b1;
        slot = 3'(k);
        dh = 6'(h11 - sx(k));
        dv = 6'(v11 - sy(k));
      end
  end
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      en_sh <= '0;
      cur_sh <= '0;
      addr_out <= '0;
      slot1 <= '0;
      hit1 <= 1'b0;
      brd1 <= 1'b0;
      act1 <= 1'b0;
      q_r <= '0;
      addr_outh <= '0;
      hit2 <= 1'b0;
      brd2 <= 1'b0;
      act2 <= 1'b0;
      rgb <= '0;
      rgb_valid <= 1'b0;
    end else begin
      if (hcount == 10'd0 && vcount == 10'd0) begin
        en_sh <= slot_en;
        cur_sh <= cursor;
      end
      hit1 <= active && hit;
      act1 <= active;
      brd1 <= active && hit && on_edge && slot == cur_sh && cur_sh >= 3'd2;
      if (active && hit) begin
        addr_out <= {slot, dv, dh};
        slot1 <= slot;
      end
      q_r <= q;
      addr_outh <= {1'b0, slot1, q};
      hit2 <= hit1;
      brd2 <= brd1;
      act2 <= act1;
      rgb_valid <= act2;
      rgb <= !act2 ? 24'h000000 : brd2 ? HL_RGB : (!hit2 || q_r == 4'd0) ? BG_RGB : qh;
    end
  end
endmodule

// File: tb/tb_sprite_pixel_fetch.sv
// tb_sprite_pixel_fetch: directed table, cursor/reset sequences and random streaming against a slot-geometry model
module tb_sprite_pixel_fetch;
  localparam int BAR_X = 16, BAR_Y = 400, BAR_STEP = 104;
  localparam logic [23:0] BG = 24'h000000, HL = 24'hFFFF00;
  logic clk = 0, reset = 0, active = 0;
  logic [9:0] hcount = 0, vcount = 0;
  logic [7:0] slot_en = 0, addr_outh;
  logic [2:0] cursor = 0;
  logic [14:0] addr_out;
  logic [3:0] q = 0;
  logic [23:0] qh = 0, rgb;
  logic rgb_valid;
  logic [3:0] pix [0:32767];
  logic [23:0] hdr [0:255];
  int checks = 0, errors = 0;
  typedef struct {logic [23:0] rgb; logic valid;} px_t;
  typedef struct {int h; int v; bit act; int addr; bit ch; logic [7:0] addrh; logic [23:0] rgb; logic valid;} vec_t;
  px_t pipe[$];
  logic [7:0] m_en;
  logic [2:0] m_cur;
  logic [14:0] m_addr;
  vec_t tbl[8];

  sprite_pixel_fetch dut (.clk(clk), .reset(reset), .hcount(hcount), .vcount(vcount), .active(active),
    .slot_en(slot_en), .cursor(cursor), .addr_out(addr_out), .q(q), .addr_outh(addr_outh), .qh(qh),
    .rgb(rgb), .rgb_valid(rgb_valid));

  always #5 clk = ~clk;
  always @(negedge clk) begin
    q <= pix[addr_out];
    qh <= hdr[addr_outh];
  end

  function automatic int slot_x(int k);
    return k == 0 ? 64 : k == 1 ? 384 : BAR_X + (k - 2) * BAR_STEP;
  endfunction
  function automatic int slot_y(int k);
    return k < 2 ? 48 : BAR_Y;
  endfunction

  task automatic chk(string name, logic [31:0] got, logic [31:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s got %h want %h", name, got, want);
    end
  endtask

  task automatic model_reset();
    m_en = 0;
    m_cur = 0;
    m_addr = 0;
    pipe.delete();
    pipe.push_back('{24'h0, 1'b0});
    pipe.push_back('{24'h0, 1'b0});
  endtask

  task automatic step(int h, int v, bit a);
    px_t e;
    int hs, dh, dv;
    bit bd;
    logic [3:0] qq;
    hcount = 10'(h);
    vcount = 10'(v);
    active = a;
    hs = -1;
    for (int k = 0; k < 8; k++)
      if (hs < 0 && m_en[k] && h >= slot_x(k) && h <= slot_x(k) + 63 && v >= slot_y(k) && v <= slot_y(k) + 63) hs = k;
    e.valid = a;
    e.rgb = a ? BG : 24'h0;
    if (a && hs >= 0) begin
      dh = h - slot_x(hs);
      dv = v - slot_y(hs);
      m_addr = 15'(hs * 4096 + dv * 64 + dh);
      bd = (dh == 0 || dh == 63 || dv == 0 || dv == 63) && hs == int'(m_cur) && m_cur >= 2;
      qq = pix[m_addr];
      e.rgb = bd ? HL : qq == 0 ? BG : hdr[{1'b0, 3'(hs), qq}];
    end
    pipe.push_back(e);
    @(posedge clk);
    #1;
    chk("addr_out", 32'(addr_out), 32'(m_addr));
    e = pipe.pop_front();
    chk("rgb", 32'(rgb), 32'(e.rgb));
    chk("rgb_valid", 32'(rgb_valid), 32'(e.valid));
    if (h == 0 && v == 0) begin
      m_en = slot_en;
      m_cur = cursor;
    end
  endtask

  task automatic pixel_rgb(string name, int h, int v, logic [23:0] want);
    step(h, v, 1);
    step(1023, 1023, 0);
    step(1023, 1023, 0);
    chk(name, 32'(rgb), 32'(want));
  endtask

  initial begin
    for (int i = 0; i < 32768; i++) pix[i] = 4'($urandom_range(0, 15));
    for (int i = 0; i < 256; i++) hdr[i] = 24'($urandom);
    pix[0] = 5;      hdr[8'h05] = 24'h123456;
    pix[4095] = 7;   hdr[8'h07] = 24'hABCDEF;
    pix[13578] = 9;  hdr[8'h39] = 24'h0A0B0C;
    pix[17024] = 0;
    pix[4421] = 0;
    pix[20480] = 3;  hdr[8'h53] = 24'h112233;
    tbl[0] = '{64, 48, 1, 0, 1, 8'h05, 24'h123456, 1};
    tbl[1] = '{127, 111, 1, 4095, 1, 8'h07, 24'hABCDEF, 1};
    tbl[2] = '{128, 111, 1, 4095, 0, 8'h00, BG, 1};
    tbl[3] = '{130, 420, 1, 13578, 1, 8'h39, 24'h0A0B0C, 1};
    tbl[4] = '{224, 410, 1, 17024, 1, 8'h40, HL, 1};
    tbl[5] = '{389, 53, 1, 4421, 1, 8'h10, BG, 1};
    tbl[6] = '{64, 48, 0, 4421, 0, 8'h00, 24'h0, 0};
    tbl[7] = '{328, 400, 1, 20480, 1, 8'h53, 24'h112233, 1};
    #2 reset = 1;
    #1;
    chk("rst_addr_out", 32'(addr_out), 0);
    chk("rst_addr_outh", 32'(addr_outh), 0);
    chk("rst_rgb", 32'(rgb), 0);
    chk("rst_rgb_valid", 32'(rgb_valid), 0);
    repeat (2) @(posedge clk);
    @(negedge clk) reset = 0;
    model_reset();
    pixel_rgb("pre_latch_no_draw", 64, 48, BG);
    slot_en = 8'hFF;
    cursor = 4;
    step(0, 0, 1);
    foreach (tbl[i]) begin
      step(tbl[i].h, tbl[i].v, tbl[i].act);
      chk($sformatf("tbl%0d_addr", i), 32'(addr_out), 32'(tbl[i].addr));
      step(1023, 1023, 0);
      if (tbl[i].ch) chk($sformatf("tbl%0d_addrh", i), 32'(addr_outh), 32'(tbl[i].addrh));
      step(1023, 1023, 0);
      chk($sformatf("tbl%0d_rgb", i), 32'(rgb), 32'(tbl[i].rgb));
      chk($sformatf("tbl%0d_valid", i), 32'(rgb_valid), 32'(tbl[i].valid));
    end
    cursor = 5;
    pixel_rgb("midframe_old_cursor", 224, 410, HL);
    pixel_rgb("midframe_new_not_yet", 328, 400, 24'h112233);
    step(0, 0, 1);
    pixel_rgb("newframe_cursor5", 328, 400, HL);
    pixel_rgb("newframe_slot4_plain", 224, 410, BG);
    for (int i = 0; i < 3000; i++) begin
      int k, h, v;
      if ($urandom_range(0, 199) == 0) begin
        slot_en = 8'($urandom);
        cursor = 3'($urandom);
      end
      k = $urandom_range(0, 7);
      if ($urandom_range(0, 99) == 0) begin
        h = 0;
        v = 0;
      end else if ($urandom_range(0, 3) == 0) begin
        h = $urandom_range(0, 1023);
        v = $urandom_range(0, 1023);
      end else begin
        h = slot_x(k) + $urandom_range(0, 80) - 8;
        v = slot_y(k) + $urandom_range(0, 80) - 8;
      end
      step(h, v, $urandom_range(0, 7) != 0);
    end
    slot_en = 8'hFF;
    cursor = 2;
    step(0, 0, 1);
    for (int i = 0; i < 4; i++) step(64 + i, 50, 1);
    #2 reset = 1;
    #1;
    chk("midline_rst_addr_out", 32'(addr_out), 0);
    chk("midline_rst_addr_outh", 32'(addr_outh), 0);
    chk("midline_rst_rgb", 32'(rgb), 0);
    chk("midline_rst_rgb_valid", 32'(rgb_valid), 0);
    @(negedge clk) reset = 0;
    model_reset();
    for (int i = 0; i < 6; i++) step(64 + i, 50, 1);
    pixel_rgb("post_rst_no_draw", 70, 50, BG);
    step(0, 0, 1);
    for (int i = 0; i < 6; i++) step(64 + i, 50, 1);
    pixel_rgb("post_frame_draw", 64, 48, 24'h123456);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
